// File: rtl/burst_controller_if.sv
// -----------------------------------------------------------------------------
// burst_controller_if
// Bundles the control/status signals of burst_controller.
//   master : drives enable, trig, cycle_count, holdoff, phase_msb
//            and observes the NCO controls and burst status.
//   slave  : the burst controller itself.
// Signals
//   enable      burst mode enable; low forces IDLE
//   trig        single-cycle trigger pulse
//   cycle_count waveform periods per burst (0 behaves as 1)
//   holdoff     rearm holdoff length in clocks
//   phase_msb   NCO phase accumulator bit 31
//   nco_run     accumulator advance enable
//   nco_clear   single-cycle accumulator zero request
//   busy        high in START, BURST, HOLDOFF
//   done        single-cycle pulse on normal burst completion
//   cycles_done completed periods in the current/last burst
//   state       IDLE=0, START=1, BURST=2, HOLDOFF=3
// -----------------------------------------------------------------------------
interface burst_controller_if #(
  parameter int CYC_W  = 16,
  parameter int HOLD_W = 24
);
  logic              enable;
  logic              trig;
  logic [CYC_W-1:0]  cycle_count;
  logic [HOLD_W-1:0] holdoff;
  logic              phase_msb;
  logic              nco_run;
  logic              nco_clear;
  logic              busy;
  logic              done;
  logic [CYC_W-1:0]  cycles_done;
  logic [1:0]        state;

  modport master (
    output enable, trig, cycle_count, holdoff, phase_msb,
    input  nco_run, nco_clear, busy, done, cycles_done, state
  );

  modport slave (
    input  enable, trig, cycle_count, holdoff, phase_msb,
    output nco_run, nco_clear, busy, done, cycles_done, state
  );
endinterface

// File: rtl/burst_controller.sv
// -----------------------------------------------------------------------------
// burst_controller
// Gates an NCO for a programmable number of waveform periods after a trigger,
// then holds off rearming for a programmable number of clocks.
// Ports
//   clk   : system clock (100 MHz), sole clock
//   rst_n : asynchronous active-low reset
//   bus   : burst_controller_if.slave (see interface file for signal list)
// All outputs come straight from flops.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for trig with enable high; NCO stopped
// START   | one cycle; request accumulator clear, arm wrap detector
// BURST   | NCO running; count phase_msb 1->0 wraps up to the target
// HOLDOFF | NCO stopped; down-count latched holdoff, triggers ignored
// -----------------------------------------------------------------------------
module burst_controller #(
  parameter int CYC_W  = 16,
  parameter int HOLD_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  burst_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_BURST   = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  state_t            r_state;
  logic              r_nco_run;
  logic              r_nco_clear;
  logic              r_busy;
  logic              r_done;
  logic              r_msb_d;
  logic [CYC_W-1:0]  r_cycles_done;
  logic [CYC_W-1:0]  r_target;
  logic [HOLD_W-1:0] r_holdoff;
  logic [HOLD_W-1:0] r_hold_cnt;

  logic              w_wrap;
  logic [CYC_W-1:0]  w_cycles_inc;

  // A wrap is the accumulator MSB falling; r_msb_d is held at 0 through START
  // so a stale MSB from before the clear cannot look like a wrap.
  assign w_wrap       = (r_state == ST_BURST) && r_msb_d && !bus.phase_msb;
  assign w_cycles_inc = (r_cycles_done == CYC_MAX) ? r_cycles_done
                                                    : r_cycles_done + CYC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_nco_run     <= 1'b0;
      r_nco_clear   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_msb_d       <= 1'b0;
      r_cycles_done <= '0;
      r_target      <= '0;
      r_holdoff     <= '0;
      r_hold_cnt    <= '0;
    end else begin
      r_nco_clear <= 1'b0;
      r_done      <= 1'b0;
      r_msb_d     <= bus.phase_msb;

      if (!bus.enable) begin
        // Abort from any state; cycles_done keeps the partial count.
        r_state    <= ST_IDLE;
        r_nco_run  <= 1'b0;
        r_busy     <= 1'b0;
        r_hold_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_nco_run <= 1'b0;
            if (bus.trig) begin
              r_state       <= ST_START;
              r_nco_clear   <= 1'b1;
              r_busy        <= 1'b1;
              r_cycles_done <= '0;
              r_target      <= (bus.cycle_count == '0) ? CYC_W'(1) : bus.cycle_count;
              r_holdoff     <= bus.holdoff;
              r_msb_d       <= 1'b0;
            end
          end

          ST_START: begin
            r_msb_d   <= 1'b0;
            r_state   <= ST_BURST;
            r_nco_run <= 1'b1;
          end

          ST_BURST: begin
            if (w_wrap) begin
              r_cycles_done <= w_cycles_inc;
              if (w_cycles_inc == r_target) begin
                r_nco_run  <= 1'b0;
                r_done     <= 1'b1;
                r_hold_cnt <= r_holdoff;
                if (r_holdoff != '0) begin
                  r_state <= ST_HOLDOFF;
                end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                end
              end
            end
          end

          ST_HOLDOFF: begin
            // Terminal compare at 1 so the counter lands on 0 as IDLE is
            // entered, giving exactly 'holdoff' cycles in this state.
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            if (r_hold_cnt == HOLD_W'(1)) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end

          default: begin
            r_state   <= ST_IDLE;
            r_nco_run <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.nco_run     = r_nco_run;
  assign bus.nco_clear   = r_nco_clear;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.cycles_done = r_cycles_done;
  assign bus.state       = r_state;

endmodule
